// File: rtl/game_fsm.sv
// Round/lives/score controller for the frog game, paced by frame_tick.
// Define GAME_FSM_HISCORE_EN to keep a best-score register; otherwise hi_score is tied to 0.
module game_fsm #(
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned DEATH_FRAMES = 60,
    parameter int unsigned SCORE_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               collision,
    input  logic               reached_end,
    output logic [1:0]         state,
    output logic               round_reset,
    output logic [2:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hi_score,
    output logic               flash
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StPlay  = 2'b01,
        StDying = 2'b10,
        StOver  = 2'b11
    } state_e;

    localparam logic [2:0]         LivesInit = 3'(LIVES_INIT);
    localparam logic [7:0]         DeathInit = 8'(DEATH_FRAMES);
    localparam logic [SCORE_W-1:0] ScoreMax  = '1;

    state_e             state_q, state_d;
    logic               round_reset_q, round_reset_d;
    logic [2:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [7:0]         timer_q, timer_d;
    logic               armed_q, armed_d;
    logic               flash_q, flash_d;
    logic               start_prev_q;
    logic               start_rise;

    assign start_rise = start_btn & ~start_prev_q;

    always_comb begin
        state_d       = state_q;
        round_reset_d = 1'b0;
        lives_d       = lives_q;
        score_d       = score_q;
        timer_d       = timer_q;
        armed_d       = armed_q;

        unique case (state_q)
            StIdle, StOver: begin
                if (start_rise) begin
                    state_d       = StPlay;
                    lives_d       = LivesInit;
                    score_d       = '0;
                    round_reset_d = 1'b1;
                end
            end
            StPlay: begin
                // Collision has priority over a simultaneous goal.
                if (armed_q && collision) begin
                    state_d = StDying;
                    lives_d = lives_q - 3'd1;
                    timer_d = DeathInit;
                end else if (armed_q && reached_end) begin
                    if (score_q != ScoreMax) begin
                        score_d = score_q + 1'b1;
                    end
                    round_reset_d = 1'b1;
                end
            end
            StDying: begin
                if (frame_tick) begin
                    timer_d = timer_q - 8'd1;
                    if (timer_q == 8'd1) begin
                        if (lives_q == 3'd0) begin
                            state_d = StOver;
                        end else begin
                            state_d       = StPlay;
                            round_reset_d = 1'b1;
                        end
                    end
                end
            end
        endcase

        // Inputs stay masked until the frog has had a full frame to return to its start row.
        if (round_reset_d || (state_q == StPlay && state_d == StDying)) begin
            armed_d = 1'b0;
        end else if (frame_tick) begin
            armed_d = 1'b1;
        end

        flash_d = (state_d == StDying) && timer_d[2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            round_reset_q <= 1'b0;
            lives_q       <= LivesInit;
            score_q       <= '0;
            timer_q       <= 8'd0;
            armed_q       <= 1'b0;
            flash_q       <= 1'b0;
            start_prev_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            round_reset_q <= round_reset_d;
            lives_q       <= lives_d;
            score_q       <= score_d;
            timer_q       <= timer_d;
            armed_q       <= armed_d;
            flash_q       <= flash_d;
            start_prev_q  <= start_btn;
        end
    end

`ifdef GAME_FSM_HISCORE_EN
    logic [SCORE_W-1:0] hi_score_q, hi_score_d;

    always_comb begin
        hi_score_d = hi_score_q;
        if (state_d == StOver && state_q != StOver && score_q > hi_score_q) begin
            hi_score_d = score_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_score_q <= '0;
        end else begin
            hi_score_q <= hi_score_d;
        end
    end

    assign hi_score = hi_score_q;
`else
    assign hi_score = '0;
`endif

    assign state       = state_q;
    assign round_reset = round_reset_q;
    assign lives       = lives_q;
    assign score       = score_q;
    assign flash       = flash_q;

endmodule

// File: tb/tb_game_fsm.sv
// Bench for game_fsm: a rules-level game model checked every cycle against two DUTs
// (SCORE_W = 8 and SCORE_W = 2) sharing one stimulus stream, plus hand-computed spot checks.
module tb_game_fsm;

    logic clk = 1'b0;
    logic reset, frame_tick, start_btn, collision, reached_end;

    logic [1:0] st8, st2;
    logic       rr8, rr2, fl8, fl2;
    logic [2:0] lv8, lv2;
    logic [7:0] sc8, hi8;
    logic [1:0] sc2, hi2;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    game_fsm u_dut8 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
        .collision(collision), .reached_end(reached_end), .state(st8), .round_reset(rr8),
        .lives(lv8), .score(sc8), .hi_score(hi8), .flash(fl8)
    );

    game_fsm #(.SCORE_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
        .collision(collision), .reached_end(reached_end), .state(st2), .round_reset(rr2),
        .lives(lv2), .score(sc2), .hi_score(hi2), .flash(fl2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // Game-rules model: 0 idle, 1 play, 2 dying, 3 over; goals counted unbounded.
    int m_state = 0, m_lives = 3, m_goals = 0, m_timer = 0, m_hi8 = 0, m_hi2 = 0;
    bit m_armed = 0, m_prev = 1, m_rr = 0;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_step();
        bit rise, pulse, died;
        rise  = start_btn && !m_prev;
        pulse = 0;
        died  = 0;
        m_prev = start_btn;
        if (reset) begin
            m_state = 0; m_lives = 3; m_goals = 0; m_timer = 0;
            m_hi8 = 0; m_hi2 = 0; m_armed = 0; m_prev = 1;
        end else begin
            case (m_state)
                0, 3: if (rise) begin
                    m_state = 1; m_lives = 3; m_goals = 0; pulse = 1;
                end
                1: if (m_armed && collision) begin
                    m_state = 2; m_lives--; m_timer = 60; died = 1;
                end else if (m_armed && reached_end) begin
                    m_goals++; pulse = 1;
                end
                default: if (frame_tick) begin
                    m_timer--;
                    if (m_timer == 0) begin
                        if (m_lives == 0) begin
                            m_state = 3;
                            if (sat(m_goals, 255) > m_hi8) m_hi8 = sat(m_goals, 255);
                            if (sat(m_goals, 3) > m_hi2) m_hi2 = sat(m_goals, 3);
                        end else begin
                            m_state = 1; pulse = 1;
                        end
                    end
                end
            endcase
            if (pulse || died) m_armed = 0;
            else if (frame_tick) m_armed = 1;
        end
        m_rr = pulse;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("state", st8, m_state);
            check("state_w2", st2, m_state);
            check("round_reset", rr8, m_rr);
            check("lives", lv8, m_lives);
            check("score", sc8, sat(m_goals, 255));
            check("score_w2", sc2, sat(m_goals, 3));
            check("flash", fl8, (m_state == 2) ? ((m_timer >> 2) & 1) : 0);
`ifdef GAME_FSM_HISCORE_EN
            check("hi_score", hi8, m_hi8);
            check("hi_score_w2", hi2, m_hi2);
`else
            check("hi_score", hi8, 0);
            check("hi_score_w2", hi2, 0);
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Ends just after the last tick's edge so callers can check that edge's result.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            if (i != 0) cyc(3);
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
        end
    endtask

    task automatic goal();
        ticks(1);
        cyc(3);
        reached_end = 1'b1;
        cyc(1);
        reached_end = 1'b0;
        cyc(2);
    endtask

    task automatic die();
        ticks(1);
        cyc(2);
        collision = 1'b1;
        cyc(1);
        collision = 1'b0;
        check("lit_dying_entry", st8, 2'b10);
        cyc(3);
        ticks(60);
        cyc(3);
    endtask

    initial begin
        reset = 1'b1; start_btn = 1'b1; frame_tick = 1'b0;
        collision = 1'b0; reached_end = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(10);
        check("lit_held_btn_state", st8, 2'b00);
        check("lit_reset_lives", lv8, 3);
        check("lit_reset_score", sc8, 0);

        start_btn = 1'b0; cyc(1);
        start_btn = 1'b1; cyc(1);
        check("lit_start_state", st8, 2'b01);
        check("lit_start_rr", rr8, 1);
        cyc(1);
        check("lit_rr_one_cycle", rr8, 0);
        start_btn = 1'b0;

        reached_end = 1'b1; cyc(3);
        check("lit_unarmed_goal", sc8, 0);
        frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
        cyc(1);
        check("lit_goal_score", sc8, 1);
        check("lit_goal_rr", rr8, 1);
        cyc(3);
        check("lit_goal_held", sc8, 1);
        reached_end = 1'b0;

        start_btn = 1'b1; cyc(1); start_btn = 1'b0; cyc(1);
        check("lit_start_in_play", st8, 2'b01);

        ticks(1); cyc(2);
        collision = 1'b1; reached_end = 1'b1; cyc(1);
        collision = 1'b0; reached_end = 1'b0;
        check("lit_both_state", st8, 2'b10);
        check("lit_both_lives", lv8, 2);
        check("lit_both_score", sc8, 1);
        check("lit_flash_60", fl8, 1);
        cyc(3); ticks(1);
        check("lit_flash_59", fl8, 0);
        cyc(3); ticks(58);
        check("lit_dying_59_ticks", st8, 2'b10);
        cyc(3); ticks(1);
        check("lit_revive_state", st8, 2'b01);
        check("lit_revive_rr", rr8, 1);
        cyc(3);

        repeat (4) goal();
        check("lit_score_5", sc8, 5);
        check("lit_score_w2_sat", sc2, 3);

        die(); die();
        check("lit_over_state", st8, 2'b11);
        check("lit_over_lives", lv8, 0);
`ifdef GAME_FSM_HISCORE_EN
        check("lit_hi_5", hi8, 5);
`endif

        start_btn = 1'b1; cyc(1);
        check("lit_restart_state", st8, 2'b01);
        check("lit_restart_lives", lv8, 3);
        check("lit_restart_score", sc8, 0);
        start_btn = 1'b0; cyc(2);

        repeat (2) goal();
        die(); die(); die();
        check("lit_over2_state", st8, 2'b11);
`ifdef GAME_FSM_HISCORE_EN
        check("lit_hi_kept", hi8, 5);
`endif

        start_btn = 1'b1; cyc(1); start_btn = 1'b0; cyc(2);
        ticks(1); cyc(2);
        collision = 1'b1; cyc(1); collision = 1'b0;
        cyc(3); ticks(5);
        reset = 1'b1; cyc(1);
        check("lit_reset_dying_state", st8, 2'b00);
        check("lit_reset_dying_rr", rr8, 0);
        check("lit_reset_dying_hi", hi8, 0);
        reset = 1'b0;
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/game_fsm.md
# game_fsm

Round/lives/score controller for the frog game. Sits directly downstream of the collision and goal-detection logic in the top level: it consumes the `collision` and `reached_end` levels, then drives the `state` bus and the round `reset` pulse back into `frog` and `cars`. It also supplies the lives and score counts and a flash bit used by the renderers. All sequencing is frame-paced via a one-cycle `frame_tick` derived from VSYNC.

## Interface
- `LIVES_INIT`, default 3: lives loaded at game start, range 1..7.
- `DEATH_FRAMES`, default 60: frames spent in DYING, range 1..255.
- `SCORE_W`, default 8: score counter width.
- `clk`  in  1  pixel clock (25.1 MHz).
- `reset`  in  1  synchronous, active-high; clears all state on the next `clk` edge.
- `frame_tick`  in  1  one-cycle pulse per frame.
- `start_btn`  in  1  level, already synchronous to `clk`.
- `collision`  in  1  frog/car overlap level.
- `reached_end`  in  1  frog in goal row level.
- `state`  out  2  encoding: 00 IDLE, 01 PLAY, 10 DYING, 11 OVER.
- `round_reset`  out  1  one-cycle pulse; returns frog and cars to their start positions.
- `lives`  out  3  remaining lives.
- `score`  out  SCORE_W  goals reached this game.
- `hi_score`  out  SCORE_W  best score (see Configuration).
- `flash`  out  1  blink enable for the frog sprite.

## Operation
- Reset values:
  - `state` = IDLE, `round_reset` = 0.
  - `lives` = `LIVES_INIT`, `score` = 0, `hi_score` = 0, `flash` = 0.
  - `armed` = 0, timer = 0, `start_prev` = 1. Because `start_prev` resets to 1, a button held through reset does not start a game.
- `start_rise` = `start_btn` & ~`start_prev`; `start_prev` registers `start_btn` every cycle.
- `armed` gating:
  - `armed` is cleared whenever `round_reset` is asserted.
  - It is set on the first `frame_tick` after that.
  - `collision` and `reached_end` are ignored while `armed` = 0. This covers the frog-reset latency.
- IDLE: on `start_rise`, go to PLAY with `lives` = `LIVES_INIT`, `score` = 0, and pulse `round_reset`.
- PLAY, when `armed`:
  - `collision` = 1 → go to DYING, `lives` decrements by 1, timer = `DEATH_FRAMES`, `armed` = 0.
  - else `reached_end` = 1 → stay in PLAY, `score` + 1 (saturating at 2^`SCORE_W`−1), pulse `round_reset`.
- Simultaneous `collision` and `reached_end`: collision wins, score unchanged.
- DYING:
  - Each `frame_tick` decrements the timer.
  - When the decrement takes the timer to 0: if `lives` = 0, go to OVER; else go to PLAY and pulse `round_reset`.
  - Collision and goal inputs are ignored.
- OVER: on `start_rise`, do the same as from IDLE (new game, straight to PLAY).
- `flash` = timer bit 2 while in DYING, giving a toggle every 4 frames; 0 in all other states.
- Lives never underflow: decrement happens only in PLAY, and PLAY is never entered with `lives` = 0.

## Timing
- All outputs are registered.
- An input event sampled at edge N is visible on `state`, `lives`, `score` and `round_reset` after edge N. So `round_reset` is high for exactly the cycle following the decision.
- A `frame_tick` coincident with the cycle that enters DYING is not counted. DYING lasts exactly `DEATH_FRAMES` subsequent ticks.
- `reset` asserted mid-game (any state) returns to IDLE on the next edge. No `round_reset` pulse is emitted.
- `start_rise` in PLAY or DYING is ignored.

## Configuration
- `GAME_FSM_HISCORE_EN` defined:
  - `hi_score` updates to `score` on the cycle OVER is entered, if `score` > `hi_score`.
  - `hi_score` is cleared only by `reset`.
- `GAME_FSM_HISCORE_EN` not defined: `hi_score` is constant 0 and no register is inferred.

## Test plan
- Reset with `start_btn` held high, then hold 10 cycles → `state` stays 00, `lives` = 3, `score` = 0. Release and press → `state` = 01 next cycle, one-cycle `round_reset`.
- PLAY, `reached_end` asserted before the first `frame_tick` → ignored. After the tick, `reached_end` = 1 → `score` = 1, single `round_reset`, no further increment until the next tick even if the input stays high.
- PLAY armed, `collision` and `reached_end` both 1 → `state` = 10, `lives` = 2, `score` unchanged, `flash` toggles every 4 ticks. After 60 ticks → `state` = 01 with `round_reset`.
- Three collisions from `lives` = 3 → after the third DYING, `state` = 11, `lives` = 0. Press start → `state` = 01, `lives` = 3, `score` = 0.
- `SCORE_W` = 2, four goals → `score` saturates at 3.
- With `GAME_FSM_HISCORE_EN`: score 5, game over → `hi_score` = 5. Next game score 2, over → `hi_score` stays 5. Assert `reset` mid-DYING → `state` = 00 on the next edge.
